lab3_mem_blocking_cache_assoc_ctrl: RTL and testbench

Control unit for a parametrised N-way set-associative, write-back, write-allocate blocking cache.
- Generalises the direct-mapped controller in three ways: configurable ways and sets, per-set LRU replacement, and a new flush request type that writes back every dirty line.
- Pairs with a matching datapath that holds per-way tag/data arrays and a flush-index address override.
- Sits between the processor-side cache interface and the memory-side interface.

---
 rtl/lab3_mem_blocking_cache_assoc_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_lab3_mem_blocking_cache_assoc_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab3_mem_blocking_cache_assoc_ctrl.sv
// Control unit for an N-way set-associative, write-back, write-allocate
// blocking cache. Owns valid/dirty/LRU state and sequences the datapath
// through hit, miss (evict + refill), init and whole-cache flush requests.
//
// Handshakes: every interface uses valid/ready. A beat moves on the rising
// edge where both are 1; the producer holds valid and its payload steady
// until that edge. Here cachereq_rdy is raised only in IDLE, cacheresp_val
// only in WAIT, memreq_val in ER/RR/FER and memresp_rdy in EW/RW/FEW, so a
// stalled partner freezes the FSM with every output held.
module lab3_mem_blocking_cache_assoc_ctrl #(
  parameter int p_num_ways  = 2,
  parameter int p_num_sets  = 8,
  parameter int p_idx_shamt = 0,
  localparam int c_w  = p_num_ways,
  localparam int c_lw = (p_num_ways > 1) ? $clog2(p_num_ways) : 1,
  localparam int c_iw = $clog2(p_num_sets)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cachereq_val,
  output logic            cachereq_rdy,
  output logic            cacheresp_val,
  input  logic            cacheresp_rdy,
  output logic            memreq_val,
  input  logic            memreq_rdy,
  input  logic            memresp_val,
  output logic            memresp_rdy,
  output logic            cachereq_en,
  output logic            memresp_en,
  output logic            read_data_reg_en,
  output logic            evict_addr_reg_en,
  output logic            write_data_mux_sel,
  output logic            tag_array_ren,
  output logic            data_array_ren,
  output logic [c_w-1:0]  tag_array_wen,
  output logic [c_w-1:0]  data_array_wen,
  output logic [15:0]     data_array_wben,
  output logic [c_lw-1:0] way_sel,
  output logic            idx_mux_sel,
  output logic [c_iw-1:0] flush_idx,
  output logic            memreq_addr_mux_sel,
  output logic [2:0]      read_word_mux_sel,
  output logic [2:0]      cacheresp_type,
  output logic [2:0]      memreq_type,
  output logic [1:0]      hit,
  input  logic [2:0]      cachereq_type,
  input  logic [31:0]     cachereq_addr,
  input  logic [c_w-1:0]  tag_match,
  output logic [3:0]      dbg_state
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,  TC  = 4'd1,  IN  = 4'd2,  RD    = 4'd3,
    WD    = 4'd4,  EP  = 4'd5,  ER  = 4'd6,  EW    = 4'd7,
    RR    = 4'd8,  RW  = 4'd9,  RU  = 4'd10, WAIT  = 4'd11,
    FSCAN = 4'd12, FEP = 4'd13, FER = 4'd14, FEW   = 4'd15
  } state_t;

  state_t r_state, w_state_next;

  logic [2:0]      r_type;
  logic            r_hit;
  logic [c_w-1:0]  r_way_oh;
  logic [c_iw-1:0] r_fidx;
  logic [c_w-1:0]  r_fway_oh;

  logic [c_w-1:0]  r_valid [p_num_sets];
  logic [c_w-1:0]  r_dirty [p_num_sets];
  logic [c_lw-1:0] r_age   [p_num_sets][p_num_ways];

  logic [c_iw-1:0] w_idx;
  logic [1:0]      w_word;
  logic [c_w-1:0]  w_match, w_hit_oh, w_inv, w_inv_oh, w_age_oh, w_vict_oh;
  logic            w_hit, w_vict_dirty, w_fsel, w_flast_way, w_flast_set;
  logic [c_lw-1:0] w_old_age;
  logic            w_unused;

  function automatic logic [c_lw-1:0] oh2bin(input logic [c_w-1:0] oh);
    oh2bin = '0;
    for (int w = 0; w < c_w; w++) if (oh[w]) oh2bin = c_lw'(w);
  endfunction

  assign w_idx    = c_iw'(cachereq_addr >> (4 + p_idx_shamt));
  assign w_word   = cachereq_addr[3:2];
  assign w_unused = ^cachereq_addr;

  // Lookup: hit way is the lowest matching valid way; victim is the lowest
  // invalid way, else the oldest way of the set.
  always_comb begin
    w_match  = tag_match & r_valid[w_idx];
    w_hit    = |w_match;
    w_hit_oh = w_match & (~w_match + c_w'(1));
    w_inv    = ~r_valid[w_idx];
    w_inv_oh = w_inv & (~w_inv + c_w'(1));
    w_age_oh = '0;
    for (int w = 0; w < c_w; w++)
      w_age_oh[w] = (r_age[w_idx][w] == c_lw'(c_w - 1));
    w_vict_oh    = (|w_inv) ? w_inv_oh : w_age_oh;
    w_vict_dirty = |(w_vict_oh & r_valid[w_idx] & r_dirty[w_idx]);
    w_old_age    = '0;
    for (int w = 0; w < c_w; w++)
      if (r_way_oh[w]) w_old_age = r_age[w_idx][w];
    w_fsel      = |(r_fway_oh & r_valid[r_fidx] & r_dirty[r_fidx]);
    w_flast_way = r_fway_oh[c_w-1];
    w_flast_set = (r_fidx == c_iw'(p_num_sets - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Control-owned line state, LRU ages and per-request registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_type    <= '0;
      r_hit     <= 1'b0;
      r_way_oh  <= '0;
      r_fidx    <= '0;
      r_fway_oh <= c_w'(1);
      for (int s = 0; s < p_num_sets; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < c_w; w++) r_age[s][w] <= c_lw'(w);
      end
    end else begin
      case (r_state)
        TC: begin
          r_type    <= cachereq_type;
          r_hit     <= w_hit && (cachereq_type == 3'd0 || cachereq_type == 3'd1);
          r_way_oh  <= (w_hit && cachereq_type != 3'd2) ? w_hit_oh : w_vict_oh;
          r_fidx    <= '0;
          r_fway_oh <= c_w'(1);
        end
        RU: begin
          r_valid[w_idx] <= r_valid[w_idx] | r_way_oh;
          r_dirty[w_idx] <= r_dirty[w_idx] & ~r_way_oh;
        end
        FSCAN: begin
          if (!w_fsel) begin
            if (w_flast_way) begin
              r_fway_oh <= c_w'(1);
              if (!w_flast_set) r_fidx <= r_fidx + 1'b1;
            end else begin
              r_fway_oh <= r_fway_oh << 1;
            end
          end
        end
        FEW: if (memresp_val) r_dirty[r_fidx] <= r_dirty[r_fidx] & ~r_fway_oh;
        default: ;
      endcase
      if (r_state == IN) begin
        r_valid[w_idx] <= r_valid[w_idx] | r_way_oh;
        r_dirty[w_idx] <= r_dirty[w_idx] & ~r_way_oh;
      end
      if (r_state == WD) r_dirty[w_idx] <= r_dirty[w_idx] | r_way_oh;
      if (r_state == RD || r_state == WD || r_state == IN) begin
        for (int w = 0; w < c_w; w++) begin
          if (r_way_oh[w])                       r_age[w_idx][w] <= '0;
          else if (r_age[w_idx][w] < w_old_age)  r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
        end
      end
    end
  end

  // Next-state and datapath control; everything is held at 0 during reset.
  always_comb begin
    w_state_next        = r_state;
    cachereq_rdy        = 1'b0;
    cacheresp_val       = 1'b0;
    memreq_val          = 1'b0;
    memresp_rdy         = 1'b0;
    cachereq_en         = 1'b0;
    memresp_en          = 1'b0;
    read_data_reg_en    = 1'b0;
    evict_addr_reg_en   = 1'b0;
    write_data_mux_sel  = 1'b0;
    tag_array_ren       = 1'b0;
    data_array_ren      = 1'b0;
    tag_array_wen       = '0;
    data_array_wen      = '0;
    data_array_wben     = '0;
    way_sel             = '0;
    idx_mux_sel         = 1'b0;
    flush_idx           = '0;
    memreq_addr_mux_sel = 1'b0;
    read_word_mux_sel   = 3'd0;
    cacheresp_type      = 3'd0;
    memreq_type         = 3'd0;
    hit                 = 2'b00;
    dbg_state           = 4'd0;
    if (!reset) begin
      w_state_next = IDLE;
    end else begin
      dbg_state = r_state;
      case (r_state)
        IDLE: begin
          cachereq_rdy = 1'b1;
          cachereq_en  = 1'b1;
          if (cachereq_val) w_state_next = TC;
        end
        TC: begin
          tag_array_ren = 1'b1;
          way_sel       = oh2bin(w_hit_oh);
          if      (cachereq_type == 3'd3) w_state_next = FSCAN;
          else if (cachereq_type == 3'd2) w_state_next = IN;
          else if (w_hit)                 w_state_next = (cachereq_type == 3'd1) ? WD : RD;
          else if (w_vict_dirty)          w_state_next = EP;
          else                            w_state_next = RR;
        end
        IN: begin
          way_sel         = oh2bin(r_way_oh);
          tag_array_wen   = r_way_oh;
          data_array_wen  = r_way_oh;
          data_array_wben = 16'hFFFF;
          w_state_next    = WAIT;
        end
        RD: begin
          way_sel          = oh2bin(r_way_oh);
          data_array_ren   = 1'b1;
          read_data_reg_en = 1'b1;
          w_state_next     = WAIT;
        end
        WD: begin
          way_sel         = oh2bin(r_way_oh);
          data_array_wen  = r_way_oh;
          data_array_wben = 16'hF << {w_word, 2'b00};
          w_state_next    = WAIT;
        end
        EP: begin
          way_sel           = oh2bin(r_way_oh);
          tag_array_ren     = 1'b1;
          data_array_ren    = 1'b1;
          evict_addr_reg_en = 1'b1;
          read_data_reg_en  = 1'b1;
          w_state_next      = ER;
        end
        ER: begin
          way_sel     = oh2bin(r_way_oh);
          memreq_val  = 1'b1;
          memreq_type = 3'd1;
          if (memreq_rdy) w_state_next = EW;
        end
        EW: begin
          memresp_rdy = 1'b1;
          if (memresp_val) w_state_next = RR;
        end
        RR: begin
          memreq_val          = 1'b1;
          memreq_addr_mux_sel = 1'b1;
          if (memreq_rdy) w_state_next = RW;
        end
        RW: begin
          memresp_rdy = 1'b1;
          memresp_en  = 1'b1;
          if (memresp_val) w_state_next = RU;
        end
        RU: begin
          way_sel            = oh2bin(r_way_oh);
          tag_array_wen      = r_way_oh;
          data_array_wen     = r_way_oh;
          data_array_wben    = 16'hFFFF;
          write_data_mux_sel = 1'b1;
          w_state_next       = (r_type == 3'd1) ? WD : RD;
        end
        WAIT: begin
          cacheresp_val     = 1'b1;
          cacheresp_type    = r_type;
          hit               = {1'b0, r_hit};
          read_word_mux_sel = (r_type == 3'd0) ? {1'b0, w_word} : 3'd4;
          if (cacheresp_rdy) w_state_next = IDLE;
        end
        FSCAN: begin
          idx_mux_sel = 1'b1;
          flush_idx   = r_fidx;
          way_sel     = oh2bin(r_fway_oh);
          if (w_fsel)                          w_state_next = FEP;
          else if (w_flast_way && w_flast_set) w_state_next = WAIT;
        end
        FEP: begin
          idx_mux_sel       = 1'b1;
          flush_idx         = r_fidx;
          way_sel           = oh2bin(r_fway_oh);
          tag_array_ren     = 1'b1;
          data_array_ren    = 1'b1;
          evict_addr_reg_en = 1'b1;
          read_data_reg_en  = 1'b1;
          w_state_next      = FER;
        end
        FER: begin
          idx_mux_sel = 1'b1;
          flush_idx   = r_fidx;
          way_sel     = oh2bin(r_fway_oh);
          memreq_val  = 1'b1;
          memreq_type = 3'd1;
          if (memreq_rdy) w_state_next = FEW;
        end
        FEW: begin
          idx_mux_sel = 1'b1;
          flush_idx   = r_fidx;
          way_sel     = oh2bin(r_fway_oh);
          memresp_rdy = 1'b1;
          if (memresp_val) w_state_next = FSCAN;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lab3_mem_blocking_cache_assoc_ctrl.sv
// Directed bench for the associative cache controller: a 2-way/8-set
// instance and a 1-way/16-set instance share stimulus; sel picks which
// one the driver and monitor follow. tag_match is driven by hand from the
// known cache contents of each step.
module tb_lab3_mem_blocking_cache_assoc_ctrl;

  localparam logic [3:0] S_IDLE = 4'd0, S_IN = 4'd2, S_RD = 4'd3, S_WD = 4'd4;
  localparam logic [3:0] S_EW = 4'd7, S_RR = 4'd8, S_FER = 4'd14;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        cachereq_val = 1'b0, cacheresp_rdy = 1'b1;
  logic        memreq_rdy = 1'b1, memresp_val = 1'b1;
  logic [2:0]  cachereq_type = 3'd0;
  logic [31:0] cachereq_addr = 32'd0;
  logic [1:0]  tm0 = 2'b00;
  logic        tm1 = 1'b0;
  logic        sel = 1'b0;

  // 2-way instance outputs
  logic a_creq_rdy, a_cresp_val, a_mreq_val, a_mresp_rdy, a_creq_en, a_mresp_en;
  logic a_rdr_en, a_ear_en, a_wdms, a_tren, a_dren, a_idxs, a_maddr_sel;
  logic [1:0] a_twen, a_dwen, a_hit;
  logic [15:0] a_wben;
  logic [0:0] a_way;
  logic [2:0] a_fidx, a_rwms, a_cresp_type, a_mreq_type;
  logic [3:0] a_state;

  // 1-way instance outputs
  logic b_creq_rdy, b_cresp_val, b_mreq_val, b_mresp_rdy, b_creq_en, b_mresp_en;
  logic b_rdr_en, b_ear_en, b_wdms, b_tren, b_dren, b_idxs, b_maddr_sel;
  logic [0:0] b_twen, b_dwen, b_way;
  logic [1:0] b_hit;
  logic [15:0] b_wben;
  logic [3:0] b_fidx, b_state;
  logic [2:0] b_rwms, b_cresp_type, b_mreq_type;

  lab3_mem_blocking_cache_assoc_ctrl #(.p_num_ways(2), .p_num_sets(8), .p_idx_shamt(0)) dut (
    .clk(clk), .reset(reset),
    .cachereq_val(cachereq_val), .cachereq_rdy(a_creq_rdy),
    .cacheresp_val(a_cresp_val), .cacheresp_rdy(cacheresp_rdy),
    .memreq_val(a_mreq_val), .memreq_rdy(memreq_rdy),
    .memresp_val(memresp_val), .memresp_rdy(a_mresp_rdy),
    .cachereq_en(a_creq_en), .memresp_en(a_mresp_en),
    .read_data_reg_en(a_rdr_en), .evict_addr_reg_en(a_ear_en),
    .write_data_mux_sel(a_wdms), .tag_array_ren(a_tren), .data_array_ren(a_dren),
    .tag_array_wen(a_twen), .data_array_wen(a_dwen), .data_array_wben(a_wben),
    .way_sel(a_way), .idx_mux_sel(a_idxs), .flush_idx(a_fidx),
    .memreq_addr_mux_sel(a_maddr_sel), .read_word_mux_sel(a_rwms),
    .cacheresp_type(a_cresp_type), .memreq_type(a_mreq_type), .hit(a_hit),
    .cachereq_type(cachereq_type), .cachereq_addr(cachereq_addr),
    .tag_match(tm0), .dbg_state(a_state)
  );

  lab3_mem_blocking_cache_assoc_ctrl #(.p_num_ways(1), .p_num_sets(16), .p_idx_shamt(0)) dut_dm (
    .clk(clk), .reset(reset),
    .cachereq_val(cachereq_val), .cachereq_rdy(b_creq_rdy),
    .cacheresp_val(b_cresp_val), .cacheresp_rdy(cacheresp_rdy),
    .memreq_val(b_mreq_val), .memreq_rdy(memreq_rdy),
    .memresp_val(memresp_val), .memresp_rdy(b_mresp_rdy),
    .cachereq_en(b_creq_en), .memresp_en(b_mresp_en),
    .read_data_reg_en(b_rdr_en), .evict_addr_reg_en(b_ear_en),
    .write_data_mux_sel(b_wdms), .tag_array_ren(b_tren), .data_array_ren(b_dren),
    .tag_array_wen(b_twen), .data_array_wen(b_dwen), .data_array_wben(b_wben),
    .way_sel(b_way), .idx_mux_sel(b_idxs), .flush_idx(b_fidx),
    .memreq_addr_mux_sel(b_maddr_sel), .read_word_mux_sel(b_rwms),
    .cacheresp_type(b_cresp_type), .memreq_type(b_mreq_type), .hit(b_hit),
    .cachereq_type(cachereq_type), .cachereq_addr(cachereq_addr),
    .tag_match(tm1), .dbg_state(b_state)
  );

  wire a_any = |{a_creq_rdy, a_cresp_val, a_mreq_val, a_mresp_rdy, a_creq_en, a_mresp_en,
                 a_rdr_en, a_ear_en, a_wdms, a_tren, a_dren, a_idxs, a_maddr_sel,
                 a_twen, a_dwen, a_hit, a_wben, a_way, a_fidx, a_rwms, a_cresp_type,
                 a_mreq_type, a_state};
  wire b_any = |{b_creq_rdy, b_cresp_val, b_mreq_val, b_mresp_rdy, b_creq_en, b_mresp_en,
                 b_rdr_en, b_ear_en, b_wdms, b_tren, b_dren, b_idxs, b_maddr_sel,
                 b_twen, b_dwen, b_hit, b_wben, b_way, b_fidx, b_rwms, b_cresp_type,
                 b_mreq_type, b_state};

  // view of the instance under test
  wire       c_creq_rdy  = sel ? b_creq_rdy  : a_creq_rdy;
  wire       c_cresp_val = sel ? b_cresp_val : a_cresp_val;
  wire [2:0] c_cresp_typ = sel ? b_cresp_type : a_cresp_type;
  wire       c_mreq_val  = sel ? b_mreq_val  : a_mreq_val;
  wire [2:0] c_mreq_type = sel ? b_mreq_type : a_mreq_type;
  wire       c_maddr_sel = sel ? b_maddr_sel : a_maddr_sel;
  wire [2:0] c_rwms      = sel ? b_rwms      : a_rwms;
  wire [1:0] c_hit       = sel ? b_hit       : a_hit;
  wire       c_way       = sel ? b_way[0]    : a_way[0];
  wire [3:0] c_fidx      = sel ? b_fidx      : {1'b0, a_fidx};
  wire [3:0] c_state     = sel ? b_state     : a_state;

  // scoreboard
  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int lat, n_rd, n_wr, rr_cycles, rr_ok, stall_cnt, first_mtype;
  logic acc_way, wr_way;
  logic [2:0] resp_type, resp_rwms;
  logic [1:0] resp_hit;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: one request, monitored until the response beat
  task automatic do_req(input logic [2:0] t, input logic [31:0] a, input logic [1:0] tm,
                        input int stall);
    int guard;
    lat = 0; n_rd = 0; n_wr = 0; rr_cycles = 0; rr_ok = 0; stall_cnt = 0;
    first_mtype = -1; acc_way = 1'b0; wr_way = 1'b0; guard = 0;
    @(negedge clk);
    while (!c_creq_rdy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check_eq("req_rdy_timeout", 32'd1, 32'd0);
    cachereq_type = t; cachereq_addr = a; tm0 = tm; tm1 = tm[0];
    cachereq_val = 1'b1;
    if (stall > 0) memreq_rdy = 1'b0;
    @(negedge clk);
    cachereq_val = 1'b0;
    lat = 1;
    while (!c_cresp_val && lat < 200) begin
      if (c_state == S_RD || c_state == S_WD || c_state == S_IN) acc_way = c_way;
      if (c_state == S_RR) begin
        rr_cycles++;
        if (c_mreq_val && c_mreq_type == 3'd0 && c_maddr_sel) rr_ok++;
        if (!memreq_rdy) begin
          stall_cnt++;
          if (stall_cnt > stall) memreq_rdy = 1'b1;
        end
      end
      if (c_mreq_val && memreq_rdy) begin
        if (first_mtype < 0) first_mtype = int'(c_mreq_type);
        if (c_mreq_type == 3'd1) begin
          n_wr++;
          wr_way = c_way;
          if (c_state == S_FER) begin
            if (exp_q.size() == 0) check_eq("flush_extra_wb", 32'd1, 32'd0);
            else check_eq("flush_wb_order", 32'(c_fidx), 32'(exp_q.pop_front()));
          end
        end else begin
          n_rd++;
        end
      end
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) check_eq("resp_timeout", 32'd1, 32'd0);
    resp_type = c_cresp_typ; resp_hit = c_hit; resp_rwms = c_rwms;
    memreq_rdy = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int guard;
    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_outputs_zero", 32'(a_any), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("post_rst_rdy", 32'(a_creq_rdy), 32'd1);
    check_eq("post_rst_state", 32'(a_state), 32'(S_IDLE));

    // init then read hit in set 0
    do_req(3'd2, 32'h100, 2'b00, 0);
    check_eq("init_lat", lat, 3);
    check_eq("init_type", 32'(resp_type), 32'd2);
    check_eq("init_way", 32'(acc_way), 32'd0);
    check_eq("init_memreqs", n_rd + n_wr, 0);
    do_req(3'd0, 32'h108, 2'b01, 0);
    check_eq("rdhit_lat", lat, 3);
    check_eq("rdhit_hit", 32'(resp_hit), 32'd1);
    check_eq("rdhit_word", 32'(resp_rwms), 32'd2);

    // fill both ways of set 0, touch 0x1000, then evict the 0x2000 way
    do_req(3'd1, 32'h1000, 2'b00, 0);
    check_eq("wr1000_lat", lat, 6);
    check_eq("wr1000_rd", n_rd, 1);
    check_eq("wr1000_way", 32'(acc_way), 32'd1);
    check_eq("wr1000_word", 32'(resp_rwms), 32'd4);
    do_req(3'd1, 32'h2000, 2'b00, 0);
    check_eq("wr2000_lat", lat, 6);
    check_eq("wr2000_wb", n_wr, 0);
    check_eq("wr2000_way", 32'(acc_way), 32'd0);
    do_req(3'd0, 32'h1000, 2'b10, 0);
    check_eq("rd1000_lat", lat, 3);
    check_eq("rd1000_way", 32'(acc_way), 32'd1);
    do_req(3'd0, 32'h3000, 2'b00, 0);
    check_eq("rd3000_lat", lat, 9);
    check_eq("rd3000_wb", n_wr, 1);
    check_eq("rd3000_wb_way", 32'(wr_way), 32'd0);
    check_eq("rd3000_first_req", first_mtype, 1);
    check_eq("rd3000_refill", n_rd, 1);
    check_eq("rd3000_hit", 32'(resp_hit), 32'd0);

    // refill request stalled for 5 cycles
    do_req(3'd0, 32'h020, 2'b00, 5);
    check_eq("stall_lat", lat, 11);
    check_eq("stall_rr_cycles", rr_cycles, 6);
    check_eq("stall_rr_stable", rr_ok, 6);

    // reset while waiting for the writeback response of a dirty eviction
    @(negedge clk);
    guard = 0;
    while (!a_creq_rdy && guard < 20) begin @(negedge clk); guard++; end
    cachereq_type = 3'd0; cachereq_addr = 32'h5000; tm0 = 2'b00; tm1 = 1'b0;
    cachereq_val = 1'b1; memresp_val = 1'b0;
    @(negedge clk);
    cachereq_val = 1'b0;
    guard = 0;
    while (a_state != S_EW && guard < 20) begin @(negedge clk); guard++; end
    check_eq("reach_ew", 32'(a_state), 32'(S_EW));
    check_eq("ew_resp_rdy", 32'(a_mresp_rdy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_outputs_zero", 32'(a_any), 32'd0);
    reset = 1'b1; memresp_val = 1'b1;
    @(negedge clk);
    check_eq("midrst_release_rdy", 32'(a_creq_rdy), 32'd1);
    do_req(3'd0, 32'h3000, 2'b01, 0);
    check_eq("stale_miss_lat", lat, 6);
    check_eq("stale_miss_hit", 32'(resp_hit), 32'd0);

    // flush with dirty lines in sets 1 and 5
    do_req(3'd1, 32'h010, 2'b00, 0);
    check_eq("wr010_lat", lat, 6);
    do_req(3'd1, 32'h050, 2'b00, 0);
    check_eq("wr050_lat", lat, 6);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd5);
    do_req(3'd3, 32'h0, 2'b00, 0);
    check_eq("flush_lat", lat, 26);
    check_eq("flush_wb", n_wr, 2);
    check_eq("flush_rd", n_rd, 0);
    check_eq("flush_type", 32'(resp_type), 32'd3);
    check_eq("flush_word", 32'(resp_rwms), 32'd4);
    check_eq("flush_q_empty", exp_q.size(), 0);
    do_req(3'd3, 32'h0, 2'b00, 0);
    check_eq("clean_flush_lat", lat, 18);
    check_eq("clean_flush_wb", n_wr, 0);
    do_req(3'd0, 32'h010, 2'b01, 0);
    check_eq("postflush_hit_lat", lat, 3);
    check_eq("postflush_hit", 32'(resp_hit), 32'd1);
    do_req(3'd0, 32'h110, 2'b00, 0);
    check_eq("rd110_way", 32'(acc_way), 32'd1);
    do_req(3'd0, 32'h210, 2'b00, 0);
    check_eq("rd210_lat", lat, 6);
    check_eq("rd210_wb", n_wr, 0);
    check_eq("rd210_way", 32'(acc_way), 32'd0);

    // direct-mapped instance
    sel = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("dm_rst_outputs_zero", 32'(b_any), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("dm_post_rst_rdy", 32'(b_creq_rdy), 32'd1);
    do_req(3'd1, 32'h000, 2'b00, 0);
    check_eq("dm_wr000_lat", lat, 6);
    do_req(3'd1, 32'h100, 2'b00, 0);
    check_eq("dm_wr100_lat", lat, 9);
    check_eq("dm_wr100_wb", n_wr, 1);
    do_req(3'd0, 32'h000, 2'b00, 0);
    check_eq("dm_rd000_lat", lat, 9);
    check_eq("dm_rd000_wb", n_wr, 1);
    do_req(3'd0, 32'h100, 2'b00, 0);
    check_eq("dm_rd100_lat", lat, 6);
    check_eq("dm_rd100_wb", n_wr, 0);
    do_req(3'd0, 32'h100, 2'b01, 0);
    check_eq("dm_hit_lat", lat, 3);
    check_eq("dm_hit", 32'(resp_hit), 32'd1);
    do_req(3'd3, 32'h0, 2'b00, 0);
    check_eq("dm_flush_lat", lat, 18);
    check_eq("dm_flush_wb", n_wr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
